compute_ram_sequencer: RTL

Job sequencer and port arbiter for the compute-RAM system. It replaces free-running address counters with a controlled job. It streams a configurable number of operand words from BRAM port B through the fixed-latency compute unit and writes results back through BRAM port A. It also shares port A with an external host, granting access only after in-flight writebacks have drained.

---
 rtl/compute_ram_pkg.sv | 27 ++
 rtl/valid_delay_line.sv | 57 +++++
 rtl/compute_ram_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/compute_ram_pkg.sv
// ============================================================================
// Module      : compute_ram_pkg
// Description : Shared constants and types for the compute-RAM system.
//               BRAM geometry, compute pipeline latency and the sequencer
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package compute_ram_pkg;

    localparam int BRAM_AWIDTH     = 9;
    localparam int BRAM_DWIDTH     = 40;
    localparam int COMPUTE_LATENCY = 2;
    // One BRAM read cycle ahead of the compute pipeline.
    localparam int SEQ_LATENCY     = COMPUTE_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOST  = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/valid_delay_line.sv
// ============================================================================
// Module      : valid_delay_line
// Description : LATENCY-deep 1-bit shift register tracking in-flight reads.
//               Ports:
//                 clk          - clock
//                 clear_i      - synchronous clear of every stage
//                 valid_i      - a read is issued this cycle
//                 valid_o      - tail of the line (result valid this cycle)
//                 empty_o      - no read in flight at all
//                 head_empty_o - every stage except the tail is empty, so
//                                with no new input the line is empty next cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_delay_line
    import compute_ram_pkg::*;
#(
    parameter int LATENCY = SEQ_LATENCY
) (
    input  logic clk,
    input  logic clear_i,
    input  logic valid_i,
    output logic valid_o,
    output logic empty_o,
    output logic head_empty_o
);

    // All stages except the tail (bit LATENCY-1).
    localparam logic [LATENCY-1:0] c_HEAD_MASK = {LATENCY{1'b1}} >> 1;

    logic [LATENCY-1:0] line_q;
    logic [LATENCY-1:0] line_d;

    always_comb begin
        line_d    = line_q;
        line_d[0] = valid_i;
        for (int i = 1; i < LATENCY; i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign valid_o      = line_q[LATENCY-1];
    assign empty_o      = (line_q == '0);
    assign head_empty_o = ((line_q & c_HEAD_MASK) == '0);

endmodule

`default_nettype wire

// File: rtl/compute_ram_sequencer.sv
// ============================================================================
// Module      : compute_ram_sequencer
// Description : Job sequencer and port arbiter for the compute-RAM system.
//               Streams cfg_count operand reads from port B, tracks them
//               through the fixed-latency compute unit and issues the result
//               writes on port A. Hands the ports to an external host once
//               in-flight writes have drained, then resumes the job.
//               Ports:
//                 clk, reset                  - clock, sync active-high reset
//                 start, cfg_*                - job request and its config
//                 busy, done                  - job status / completion pulse
//                 rd_en, rd_addr              - port-B read issue
//                 wr_en, wr_addr              - port-A result write
//                 ext_req, ext_gnt            - host port ownership handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compute_ram_sequencer
    import compute_ram_pkg::*;
#(
    parameter int AWIDTH  = BRAM_AWIDTH,
    parameter int LATENCY = SEQ_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] cfg_in_addr,
    input  logic [AWIDTH-1:0] cfg_out_addr,
    input  logic [AWIDTH:0]   cfg_count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [AWIDTH-1:0] rd_addr,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    input  logic              ext_req,
    output logic              ext_gnt
);

    localparam logic [AWIDTH:0] c_CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

    seq_state_t        state_q,    state_d;
    logic [AWIDTH-1:0] in_base_q,  in_base_d;
    logic [AWIDTH-1:0] out_base_q, out_base_d;
    logic [AWIDTH:0]   count_q,    count_d;
    logic [AWIDTH:0]   issued_q,   issued_d;
    logic [AWIDTH:0]   written_q,  written_d;
    logic              job_q,      job_d;     // a job is active or suspended
    logic              resume_q,   resume_d;  // turnaround cycle after HOST

    logic w_rd_en;
    logic w_tail;
    logic w_empty;
    logic w_head_empty;
    logic w_complete;
    logic w_last_write;
    logic w_done;

    valid_delay_line #(
        .LATENCY (LATENCY)
    ) u_valid_line (
        .clk          (clk),
        .clear_i      (reset),
        .valid_i      (w_rd_en),
        .valid_o      (w_tail),
        .empty_o      (w_empty),
        .head_empty_o (w_head_empty)
    );

    assign w_rd_en      = (state_q == RUN) && !resume_q && (issued_q < count_q);
    assign w_complete   = (written_q == count_q) && w_empty;
    // The write at the tail this cycle is the final one of the job.
    assign w_last_write = w_tail && ((written_q + c_CNT_ONE) == count_q);

    always_comb begin
        state_d    = state_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        count_d    = count_q;
        issued_d   = issued_q  + (w_rd_en ? c_CNT_ONE : '0);
        written_d  = written_q + (wr_en   ? c_CNT_ONE : '0);
        job_d      = job_q;
        resume_d   = 1'b0;
        w_done     = 1'b0;

        case (state_q)
            IDLE: begin
                // Host request wins; a coincident start is dropped.
                if (ext_req) begin
                    state_d = HOST;
                end else if (start) begin
                    in_base_d  = cfg_in_addr;
                    out_base_d = cfg_out_addr;
                    count_d    = cfg_count;
                    issued_d   = '0;
                    written_d  = '0;
                    job_d      = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (w_complete) begin
                    w_done  = 1'b1;
                    job_d   = 1'b0;
                    state_d = ext_req ? HOST : IDLE;
                end else if (ext_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_complete) begin
                    w_done  = 1'b1;
                    job_d   = 1'b0;
                    state_d = ext_req ? HOST : IDLE;
                end else if (w_head_empty && !w_last_write) begin
                    // Line is empty after this cycle: grant right away. If the
                    // tail write finishes the job, stay one more cycle so the
                    // completion pulse is issued from here.
                    state_d = HOST;
                end
            end
            HOST: begin
                if (!ext_req) begin
                    if (job_q) begin
                        state_d  = RUN;
                        resume_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_base_q  <= '0;
            out_base_q <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            job_q      <= 1'b0;
            resume_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            job_q      <= job_d;
            resume_q   <= resume_d;
        end
    end

    // Address sums wrap modulo 2^AWIDTH by truncation.
    assign rd_en   = w_rd_en;
    assign rd_addr = in_base_q + issued_q[AWIDTH-1:0];
    assign wr_en   = w_tail && (state_q != HOST);
    assign wr_addr = out_base_q + written_q[AWIDTH-1:0];
    assign ext_gnt = (state_q == HOST);
    assign done    = w_done;
    assign busy    = (((state_q == RUN) || (state_q == DRAIN)) && !w_complete)
                   || ((state_q == HOST) && job_q);

endmodule

`default_nettype wire
